// File: rtl/delay_ctrl_multi.sv
// Multi-channel bounded delay register with per-channel faster/slower stepping,
// Avalon-MM access and sticky saturation flags. Define DELAY_CTRL_MULTI_REPEAT_EN for hold-to-repeat.
module delay_ctrl_multi #(
    parameter int CHANNELS      = 4,
    parameter int WIDTH         = 4,
    parameter int MIN_DELAY     = 1,
    parameter int MAX_DELAY     = 15,
    parameter int INIT_DELAY    = 8,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int ADDR_W        = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       faster,
    input  logic [CHANNELS-1:0]       slower,
    output logic [CHANNELS*WIDTH-1:0] delay,
    input  logic [ADDR_W-1:0]         address,
    input  logic                      chipselect,
    input  logic                      read,
    input  logic                      write,
    input  logic [15:0]               writedata,
    output logic [15:0]               readdata
);

    localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN_DELAY);
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_DELAY);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_DELAY);

    logic [WIDTH-1:0]    delay_q [CHANNELS];
    logic [CHANNELS-1:0] prev_faster, prev_slower;
    logic [CHANNELS-1:0] min_flag, max_flag;
    logic [CHANNELS-1:0] min_set, max_set;
    logic [CHANNELS-1:0] active, edge_ev, step, chan_wr;
    logic                armed;
    logic                bus_wr, status_wr;
    logic [WIDTH-1:0]    wr_value;
    logic [15:0]         rd_mux;

    always_comb begin
        bus_wr    = chipselect && write;
        status_wr = bus_wr && (address == ADDR_W'(CHANNELS));
        chan_wr   = '0;
        active    = '0;
        edge_ev   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            chan_wr[c] = bus_wr && (address == ADDR_W'(c));
            active[c]  = faster[c] ^ slower[c];
            // armed blocks an input held through reset from looking like a fresh press
            edge_ev[c] = armed && active[c] &&
                         (faster[c] ? !prev_faster[c] : !prev_slower[c]);
        end
        if (writedata[WIDTH-1:0] < MIN_V)
            wr_value = MIN_V;
        else if (writedata[WIDTH-1:0] > MAX_V)
            wr_value = MAX_V;
        else
            wr_value = writedata[WIDTH-1:0];
    end

`ifdef DELAY_CTRL_MULTI_REPEAT_EN
    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    rpt_state_t          state_q [CHANNELS];
    rpt_state_t          state_d [CHANNELS];
    logic [CNT_W-1:0]    cnt_q   [CHANNELS];
    logic [CNT_W-1:0]    cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] dir_q, dir_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= IDLE;
                cnt_q[c]   <= '0;
            end
            dir_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            dir_q <= dir_d;
        end
    end

    // dir_q remembers which input started the hold, so switching inputs restarts it
    always_comb begin
        step  = '0;
        dir_d = dir_q;
        for (int c = 0; c < CHANNELS; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            case (state_q[c])
                IDLE: begin
                    if (edge_ev[c]) begin
                        step[c]    = 1'b1;
                        state_d[c] = HOLD;
                        cnt_d[c]   = CNT_W'(HOLD_CYCLES - 1);
                        dir_d[c]   = faster[c];
                    end
                end
                HOLD, REPEAT: begin
                    if (active[c] && (faster[c] == dir_q[c])) begin
                        if (cnt_q[c] == '0) begin
                            step[c]    = 1'b1;
                            state_d[c] = REPEAT;
                            cnt_d[c]   = CNT_W'(REPEAT_CYCLES - 1);
                        end else begin
                            cnt_d[c] = cnt_q[c] - 1'b1;
                        end
                    end else if (edge_ev[c]) begin
                        step[c]    = 1'b1;
                        state_d[c] = HOLD;
                        cnt_d[c]   = CNT_W'(HOLD_CYCLES - 1);
                        dir_d[c]   = faster[c];
                    end else begin
                        state_d[c] = IDLE;
                        cnt_d[c]   = '0;
                    end
                end
                default: begin
                    state_d[c] = IDLE;
                    cnt_d[c]   = '0;
                end
            endcase
        end
    end
`else
    logic unused_params;

    assign unused_params = (HOLD_CYCLES == 0) | (REPEAT_CYCLES == 0);
    assign step          = edge_ev;
`endif

    // A bus write to a channel takes precedence over that cycle's step, including its flag
    always_comb begin
        min_set = '0;
        max_set = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            min_set[c] = step[c] && !chan_wr[c] && faster[c] && (delay_q[c] == MIN_V);
            max_set[c] = step[c] && !chan_wr[c] && slower[c] && (delay_q[c] == MAX_V);
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (address == ADDR_W'(c))
                rd_mux = 16'(delay_q[c]);
        end
        if (address == ADDR_W'(CHANNELS))
            rd_mux = {8'(max_flag), 8'(min_flag)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++)
                delay_q[c] <= INIT_V;
            prev_faster <= '0;
            prev_slower <= '0;
            min_flag    <= '0;
            max_flag    <= '0;
            readdata    <= '0;
            armed       <= 1'b0;
        end else begin
            armed       <= 1'b1;
            prev_faster <= faster;
            prev_slower <= slower;
            for (int c = 0; c < CHANNELS; c++) begin
                if (chan_wr[c])
                    delay_q[c] <= wr_value;
                else if (step[c] && faster[c] && (delay_q[c] != MIN_V))
                    delay_q[c] <= delay_q[c] - 1'b1;
                else if (step[c] && slower[c] && (delay_q[c] != MAX_V))
                    delay_q[c] <= delay_q[c] + 1'b1;
            end
            // Set is OR-ed in after the W1C mask so a simultaneous set survives the clear
            min_flag <= (min_flag & ~(status_wr ? writedata[CHANNELS-1:0] : '0)) | min_set;
            max_flag <= (max_flag & ~(status_wr ? writedata[8 +: CHANNELS] : '0)) | max_set;
            if (chipselect && read)
                readdata <= rd_mux;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign delay[g*WIDTH +: WIDTH] = delay_q[g];
    end

endmodule

// File: tb/tb_delay_ctrl_multi.sv
// Directed testbench for delay_ctrl_multi (4 channels, 4-bit values, HOLD=10, REPEAT=3).
module tb_delay_ctrl_multi;

    logic        clk;
    logic        reset;
    logic [3:0]  faster, slower;
    logic [15:0] delay;
    logic [3:0]  address;
    logic        chipselect, read, write;
    logic [15:0] writedata;
    logic [15:0] readdata;

    int errors = 0;
    int checks = 0;

`ifdef DELAY_CTRL_MULTI_REPEAT_EN
    localparam int EXP_AFTER_11 = 10;
    localparam int EXP_FINAL    = 13;
`else
    localparam int EXP_AFTER_11 = 9;
    localparam int EXP_FINAL    = 9;
`endif

    delay_ctrl_multi #(
        .CHANNELS(4), .WIDTH(4), .MIN_DELAY(1), .MAX_DELAY(15), .INIT_DELAY(8),
        .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .ADDR_W(4)
    ) dut (
        .clk(clk), .reset(reset), .faster(faster), .slower(slower), .delay(delay),
        .address(address), .chipselect(chipselect), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] ch(input int c);
        return delay[c*4 +: 4];
    endfunction

    task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
        address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
        address = a; chipselect = 1'b1; read = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        #1;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (ch(c) !== 4'd8) begin
                errors++;
                $display("[TB] FAIL reset_delay%0d: got %0d expected 8", c, ch(c));
            end
        end
        checks++;
        if (readdata !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_readdata: got %h expected 0000", readdata);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        bus_read(4'd4, rd);
        checks++;
        if (rd !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_status: got %h expected 0000", rd);
        end
    endtask

    task automatic test_write();
        logic [15:0] rd;
        bus_write(4'd2, 16'h0003);
        checks++;
        if (ch(2) !== 4'd3) begin
            errors++;
            $display("[TB] FAIL write_3: got %0d expected 3", ch(2));
        end
        bus_write(4'd2, 16'h0000);
        checks++;
        if (ch(2) !== 4'd1) begin
            errors++;
            $display("[TB] FAIL write_clamp_low: got %0d expected 1", ch(2));
        end
        bus_write(4'd2, 16'hFFFF);
        checks++;
        if (ch(2) !== 4'd15) begin
            errors++;
            $display("[TB] FAIL write_clamp_high: got %0d expected 15", ch(2));
        end
        bus_read(4'd4, rd);
        checks++;
        if (rd !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL write_no_sticky: got %h expected 0000", rd);
        end
        bus_read(4'd2, rd);
        checks++;
        if (rd !== 16'h000F) begin
            errors++;
            $display("[TB] FAIL read_ch2: got %h expected 000f", rd);
        end
        bus_write(4'd9, 16'h0002);
        bus_read(4'd9, rd);
        checks++;
        if (rd !== 16'h0000 || ch(0) !== 4'd8 || ch(1) !== 4'd8 || ch(2) !== 4'd15 || ch(3) !== 4'd8) begin
            errors++;
            $display("[TB] FAIL unmapped_addr: read %h delays %h expected 0000 and 8f88", rd, delay);
        end
        address = 4'd2; writedata = 16'h0005; chipselect = 1'b1; read = 1'b1; write = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        checks++;
        if (readdata !== 16'h000F || ch(2) !== 4'd5) begin
            errors++;
            $display("[TB] FAIL read_write_same: readdata %h delay %0d expected 000f and 5", readdata, ch(2));
        end
    endtask

    task automatic test_saturation();
        logic [15:0] rd;
        bus_write(4'd0, 16'h0005);
        faster[0] = 1'b1;
        @(negedge clk);
        faster[0] = 1'b0;
        checks++;
        if (ch(0) !== 4'd4) begin
            errors++;
            $display("[TB] FAIL faster_step: got %0d expected 4", ch(0));
        end
        @(negedge clk);
        bus_write(4'd0, 16'h0001);
        faster[0] = 1'b1;
        @(negedge clk);
        faster[0] = 1'b0;
        checks++;
        if (ch(0) !== 4'd1) begin
            errors++;
            $display("[TB] FAIL min_hold_value: got %0d expected 1", ch(0));
        end
        bus_read(4'd4, rd);
        checks++;
        if (rd !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL min_sticky: got %h expected 0001", rd);
        end
        bus_write(4'd4, 16'h0001);
        bus_read(4'd4, rd);
        checks++;
        if (rd !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL min_w1c: got %h expected 0000", rd);
        end
        bus_write(4'd1, 16'h000F);
        slower[1] = 1'b1;
        @(negedge clk);
        slower[1] = 1'b0;
        bus_read(4'd4, rd);
        checks++;
        if (rd !== 16'h0200 || ch(1) !== 4'd15) begin
            errors++;
            $display("[TB] FAIL max_sticky: status %h delay %0d expected 0200 and 15", rd, ch(1));
        end
        bus_write(4'd4, 16'h0200);
        faster[0] = 1'b1;
        address = 4'd4; writedata = 16'h0001; chipselect = 1'b1; write = 1'b1;
        @(negedge clk);
        faster[0] = 1'b0; chipselect = 1'b0; write = 1'b0;
        bus_read(4'd4, rd);
        checks++;
        if (rd !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL set_beats_clear: got %h expected 0001", rd);
        end
        bus_write(4'd4, 16'h0001);
    endtask

    task automatic test_repeat();
        bus_write(4'd1, 16'h0008);
        @(negedge clk);
        slower[1] = 1'b1;
        @(negedge clk);
        checks++;
        if (ch(1) !== 4'd9) begin
            errors++;
            $display("[TB] FAIL repeat_first: got %0d expected 9", ch(1));
        end
        repeat (10) @(negedge clk);
        checks++;
        if (ch(1) !== 4'(EXP_AFTER_11)) begin
            errors++;
            $display("[TB] FAIL repeat_first_tick: got %0d expected %0d", ch(1), EXP_AFTER_11);
        end
        repeat (9) @(negedge clk);
        slower[1] = 1'b0;
        checks++;
        if (ch(1) !== 4'(EXP_FINAL)) begin
            errors++;
            $display("[TB] FAIL repeat_final: got %0d expected %0d", ch(1), EXP_FINAL);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (ch(1) !== 4'(EXP_FINAL)) begin
            errors++;
            $display("[TB] FAIL repeat_stops: got %0d expected %0d", ch(1), EXP_FINAL);
        end
    endtask

    task automatic test_both_inputs();
        faster[3] = 1'b1; slower[3] = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (ch(3) !== 4'd8) begin
            errors++;
            $display("[TB] FAIL both_high: got %0d expected 8", ch(3));
        end
        slower[3] = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (ch(3) !== 4'd8) begin
            errors++;
            $display("[TB] FAIL drop_slower_no_step: got %0d expected 8", ch(3));
        end
        faster[3] = 1'b0;
        @(negedge clk);
        faster[3] = 1'b1;
        @(negedge clk);
        faster[3] = 1'b0;
        checks++;
        if (ch(3) !== 4'd7) begin
            errors++;
            $display("[TB] FAIL repress_step: got %0d expected 7", ch(3));
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [15:0] rd;
        faster[2] = 1'b1;
        @(negedge clk);
        checks++;
        if (ch(2) !== 4'd4) begin
            errors++;
            $display("[TB] FAIL hold_start: got %0d expected 4", ch(2));
        end
        bus_read(4'd2, rd);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (delay !== 16'h8888) begin
            errors++;
            $display("[TB] FAIL async_reset_delay: got %h expected 8888", delay);
        end
        checks++;
        if (readdata !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL async_reset_readdata: got %h expected 0000 (was %h)", readdata, rd);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (ch(2) !== 4'd8) begin
            errors++;
            $display("[TB] FAIL held_through_reset: got %0d expected 8", ch(2));
        end
        faster[2] = 1'b0;
        bus_read(4'd4, rd);
        checks++;
        if (rd !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL status_after_reset: got %h expected 0000", rd);
        end
    endtask

    initial begin
        reset = 1'b1;
        faster = '0; slower = '0;
        address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0; writedata = '0;
        test_reset();
        test_write();
        test_saturation();
        test_repeat();
        test_both_inputs();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/delay_ctrl_multi.md
# delay_ctrl_multi

Parametrised multi-channel successor to the single-channel delay control register. Holds CHANNELS independent delay settings, each bounded to [MIN_DELAY, MAX_DELAY]. Each setting is adjustable by per-channel faster/slower pulses with hold-to-repeat, or directly through an Avalon-MM slave port. It also exposes sticky saturation flags. It sits between the user-input debouncers and the timing generators that consume `delay`, with the bus port on the HPS lightweight bridge.

## Interface
- CHANNELS, 4: number of independent delay channels, 1..8.
- WIDTH, 4: bits per delay value, 1..16.
- MIN_DELAY, 1: lower bound, inclusive.
- MAX_DELAY, 15: upper bound, inclusive; must be ≤ 2^WIDTH-1 and ≥ MIN_DELAY.
- INIT_DELAY, 8: value loaded on reset; must be within the bounds.
- HOLD_CYCLES, 50000000: cycles from the initial step to the first repeat step.
- REPEAT_CYCLES, 5000000: cycles between subsequent repeat steps.
- ADDR_W, 4: bus address width; must satisfy 2^ADDR_W > CHANNELS.
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- faster  in  CHANNELS  per-channel decrement request, synchronous level.
- slower  in  CHANNELS  per-channel increment request, synchronous level.
- delay  out  CHANNELS*WIDTH  flat bus; channel c occupies [c*WIDTH +: WIDTH].
- address  in  ADDR_W  register select.
- chipselect  in  1  bus select.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  16  write data.
- readdata  out  16  read data, registered.

## Operation
- Register map:
  - addresses 0..CHANNELS-1: delay of channel n, R/W, zero-extended to 16 bits.
  - address CHANNELS: STATUS. Bits [7:0] are min-sticky flags per channel; bits [15:8] are max-sticky flags per channel. Writing 1 to a bit clears it (W1C).
  - other addresses: read 0, writes ignored.
- Delay write: writedata[WIDTH-1:0] is clamped to [MIN_DELAY, MAX_DELAY] before storing.
  - Clamping on write does not set the sticky flags.
- Per-channel priority, evaluated each cycle:
  1. reset
  2. bus write to that channel
  3. step event
- Step event:
  - faster XOR slower is high, and either a rising edge of that input (against its registered previous sample) or a repeat tick is due.
  - faster decrements by 1; slower increments by 1.
- Both faster and slower high: no step; repeat state is cleared.
- Saturation:
  - A faster step at MIN_DELAY leaves the value unchanged and sets min-sticky[c].
  - A slower step at MAX_DELAY leaves the value unchanged and sets max-sticky[c].
  - Values never wrap.
- If a set event and a W1C clear hit the same bit in the same cycle, set wins.
- Per-channel repeat FSM:
  - IDLE → HOLD on an initial step; the counter loads HOLD_CYCLES-1.
  - HOLD → REPEAT with a step when the counter reaches 0; the counter loads REPEAT_CYCLES-1.
  - REPEAT → REPEAT with a step at each expiry.
  - Any state → IDLE when the held input drops, or when both inputs are high.
- A bus write to a channel during HOLD/REPEAT overrides that cycle's step only; the FSM keeps counting.

## Timing
- Reset values:
  - all delay fields = INIT_DELAY
  - STATUS = 0
  - readdata = 0
  - FSMs IDLE
  - previous-sample registers 0
- Step latency: an input seen high at edge k with previous sample low updates delay at edge k, visible in the following cycle.
- Repeat steps: with initial step at edge t0, repeats occur at t0+HOLD_CYCLES, then t0+HOLD_CYCLES+m*REPEAT_CYCLES.
- Write latency: delay is updated at the edge where chipselect&&write is sampled.
- Read latency is 1: readdata is valid in the cycle after chipselect&&read and holds its value until the next read.
- Read and write in the same cycle to the same address: readdata returns the pre-write value.
- Reset asserted mid-hold or mid-transaction: all state returns to reset values immediately (asynchronous). Deassertion is synchronous to clk.

## Configuration
- DELAY_CTRL_MULTI_REPEAT_EN:
  - defined: hold-to-repeat FSMs and counters are present, as described above.
  - undefined: counters and FSMs are omitted. Only rising edges produce steps, so one press gives one step. HOLD_CYCLES and REPEAT_CYCLES are ignored.

## Test plan
- Reset with defaults → every delay field = 8, STATUS reads 0x0000, readdata = 0.
- Write 0x0003 to address 2 → channel 2 delay = 3 next cycle. Write 0x0000 → 1 (clamped). Write 0xFFFF → 15. Neither write sets sticky flags.
- Channel 0 at 1, single-cycle faster pulse → value stays 1, STATUS = 0x0001. Write 0x0001 to STATUS → 0x0000.
- HOLD_CYCLES=10, REPEAT_CYCLES=3, slower[1] held 20 cycles from 8 → steps at t0, t0+10, t0+13, t0+16, t0+19; final value 13.
  - Same stimulus with the macro undefined → final value 9.
- faster[3] and slower[3] high together for 5 cycles → value unchanged. Then drop slower[3] → no step until faster[3] is re-pressed.
- Assert reset during an active repeat hold → all outputs return to reset values asynchronously. After release, no step occurs while faster is still held.
